// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Receives a program image as a byte stream from a UART receiver and writes it
// into memory one 32-bit word at a time, holding the CPU in stall until the
// whole image has arrived and its checksum has been verified.
//
// Frame format:
//   MAGIC, count[7:0], count[15:8], count x 4 payload bytes (little-endian
//   words), checksum byte = XOR of every payload byte.
//
// Ports:
//   clk           in   1   sole clock, all state updates on the rising edge
//   rst           in   1   asynchronous, active-high reset
//   rx_data       in   8   received byte
//   rx_valid      in   1   rx_data holds a byte
//   rx_ready      out  1   loader can accept a byte this cycle
//   address       out  32  store byte address (valid while store_enable=1)
//   data_in       out  32  store data (valid while store_enable=1)
//   store_enable  out  1   one-cycle store strobe
//   is_sw         out  1   word-store qualifier, always equal to store_enable
//   core_hold     out  1   stall request to the CPU, low only once loaded
//   done          out  1   image loaded and checksum correct
//   error         out  1   frame rejected (length too large or bad checksum)
//
// Handshake: a byte is consumed on a rising clk edge where rx_valid and
// rx_ready are both high. rx_valid may drop at any time; with rx_valid low
// the loader simply waits (there is no timeout). rx_ready never depends on
// rx_valid, so the receiver can use it freely to decide whether to present a
// byte.
// -----------------------------------------------------------------------------
module boot_loader #(
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 2305
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic        store_enable,
  output logic        is_sw,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_WBYTE  = 3'd3;
  localparam logic [2:0] S_STORE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  // Word-count limit widened by one bit so the comparison below is unsigned
  // and cannot wrap for any 16-bit count.
  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [7:0]  len_lo;     // count low byte, held until the high byte arrives
  logic [15:0] count;      // words in the current frame
  logic [15:0] word_idx;   // index of the word currently being assembled
  logic [1:0]  byte_idx;   // byte lane within the current word
  logic [7:0]  acc;        // running XOR of payload bytes
  logic [31:0] word_q;     // word being assembled, presented as data_in
  logic [31:0] addr_q;     // store address, presented as address

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  logic        consume;
  logic [15:0] len_full;
  logic        len_too_big;
  logic [15:0] word_idx_nxt;
  logic        last_word;

  assign consume      = rx_valid && rx_ready;
  assign len_full     = {rx_data, len_lo};
  assign len_too_big  = {1'b0, len_full} > MAX_W;
  assign word_idx_nxt = word_idx + 16'd1;
  assign last_word    = (word_idx_nxt == count);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // Anything other than MAGIC is line noise and is dropped.
        if (consume && (rx_data == MAGIC)) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (consume) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (consume) begin
          if (len_full == 16'd0)  state_nxt = S_CSUM;
          else if (len_too_big)   state_nxt = S_ERR;
          else                    state_nxt = S_WBYTE;
        end
      end
      S_WBYTE: begin
        if (consume && (byte_idx == 2'd3)) state_nxt = S_STORE;
      end
      S_STORE: begin
        // Always exactly one cycle; no byte is taken here.
        state_nxt = last_word ? S_CSUM : S_WBYTE;
      end
      S_CSUM: begin
        if (consume) state_nxt = (rx_data == acc) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        // Terminal until reset; the CPU now owns memory.
        state_nxt = S_DONE;
      end
      S_ERR: begin
        // Stay ready so the host can retry by sending a fresh frame.
        if (consume && (rx_data == MAGIC)) state_nxt = S_LEN_LO;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      len_lo   <= 8'd0;
      count    <= 16'd0;
      word_idx <= 16'd0;
      byte_idx <= 2'd0;
      acc      <= 8'd0;
      word_q   <= 32'd0;
      addr_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_LEN_LO: begin
          if (consume) len_lo <= rx_data;
        end
        S_LEN_HI: begin
          // Every accepted header starts a fresh frame, including the
          // zero-length case that goes straight to the checksum byte.
          if (consume) begin
            count    <= len_full;
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
            acc      <= 8'd0;
          end
        end
        S_WBYTE: begin
          if (consume) begin
            word_q[{byte_idx, 3'b000} +: 8] <= rx_data;
            acc      <= acc ^ rx_data;
            byte_idx <= byte_idx + 2'd1;  // wraps to 0 after lane 3
            // Address is registered on the last lane so it is already stable
            // for the whole STORE cycle.
            if (byte_idx == 2'd3) begin
              addr_q <= BASE_ADDR + {14'd0, word_idx, 2'b00};
            end
          end
        end
        S_STORE: begin
          word_idx <= word_idx_nxt;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registered state, so reset clears them at once)
  // ---------------------------------------------------------------------------
  assign rx_ready     = (state != S_STORE) && (state != S_DONE);
  assign store_enable = (state == S_STORE);
  assign is_sw        = (state == S_STORE);
  assign core_hold    = (state != S_DONE);
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign address      = addr_q;
  assign data_in      = word_q;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
//
// Directed bench for boot_loader. A table of frames (bytes in, expected stores
// and final status out) is applied in a loop; reset corner cases are written
// out by hand. A free-running monitor checks every store against the expected
// queue and checks the status outputs that must track the state each cycle.
// -----------------------------------------------------------------------------
module tb_boot_loader;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        store_enable;
  logic        is_sw;
  logic        core_hold;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  boot_loader dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .address      (address),
    .data_in      (data_in),
    .store_enable (store_enable),
    .is_sw        (is_sw),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int passes = 0;
  logic [63:0] exp_q[$];   // {address, data} of each expected store
  logic        prev_se = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Samples late in the low phase, well away from the rising edge.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      chk("is_sw_eq_store", 64'(is_sw), 64'(store_enable));
      chk("rx_ready_decode", 64'(rx_ready), 64'(!(store_enable || done)));
      chk("core_hold_decode", 64'(core_hold), 64'(!done));
      if (store_enable) begin
        chk("strobe_one_cycle", 64'(prev_se), 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_store", {address, data_in}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("store_addr_data", {address, data_in}, exp_q.pop_front());
        end
      end
      prev_se = store_enable;
    end else begin
      prev_se = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      // rx_ready seen in the low phase means the byte goes at the next edge.
      if (rx_ready) ok = 1'b1;
      @(negedge clk);
      if (ok) break;
    end
    if (!ok) chk("byte_accept_timeout", 64'(b), 64'hFFFF);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit                do_reset;
    bit                gaps;
    int                nbytes;
    logic [0:11][7:0]  bytes;
    int                nstores;
    logic [0:1][63:0]  stores;
    logic              exp_done;
    logic              exp_error;
    logic              exp_hold;
    logic              exp_ready;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  // Two-word frame: payload XOR is 11^22^33^44^DD^CC^BB^AA = 0x44.
  localparam logic [0:11][7:0] FRAME2 =
    {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
     8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};
  localparam logic [0:11][7:0] FRAME2_BAD =
    {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
     8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h67};
  localparam logic [0:1][63:0] STORES2 =
    {64'h0000_0000_4433_2211, 64'h0000_0004_AABB_CCDD};

  function automatic vec_t mk(input bit do_reset, input bit gaps, input int nbytes,
                              input logic [0:11][7:0] bytes, input int nstores,
                              input logic [0:1][63:0] stores,
                              input logic d, input logic e, input logic h, input logic r);
    vec_t v;
    v.do_reset = do_reset; v.gaps = gaps; v.nbytes = nbytes; v.bytes = bytes;
    v.nstores = nstores; v.stores = stores;
    v.exp_done = d; v.exp_error = e; v.exp_hold = h; v.exp_ready = r;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    //                 rst gap  n   bytes                                           ns stores  done err hold rdy
    vecs[0] = mk(1, 0, 12, FRAME2, 2, STORES2, 1, 0, 0, 0);
    vecs[1] = mk(1, 0, 6, {8'h00, 8'h7F, 8'hA5, 8'h00, 8'h00, 8'h00, 48'h0},
                 0, 128'h0, 1, 0, 0, 0);
    vecs[2] = mk(1, 0, 12, FRAME2_BAD, 2, STORES2, 0, 1, 1, 1);
    vecs[3] = mk(0, 0, 4, {8'hA5, 8'h00, 8'h00, 8'h00, 64'h0},
                 0, 128'h0, 1, 0, 0, 0);
    // Count 2306: one over the limit.
    vecs[4] = mk(1, 0, 3, {8'hA5, 8'h02, 8'h09, 72'h0}, 0, 128'h0, 0, 1, 1, 1);
    // Junk is ignored in ERR, then a clean empty frame recovers.
    vecs[5] = mk(0, 0, 6, {8'h00, 8'h33, 8'hA5, 8'h00, 8'h00, 8'h00, 48'h0},
                 0, 128'h0, 1, 0, 0, 0);
    // Count 2305: exactly the limit, accepted and waiting for payload.
    vecs[6] = mk(1, 0, 3, {8'hA5, 8'h01, 8'h09, 72'h0}, 0, 128'h0, 0, 0, 1, 1);
    // One word, XOR 01^02^03^04 = 04.
    vecs[7] = mk(1, 0, 8, {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 32'h0},
                 1, {64'h0000_0000_0403_0201, 64'h0}, 1, 0, 0, 0);
    vecs[8] = mk(1, 1, 12, FRAME2, 2, STORES2, 1, 0, 0, 0);
    vecs[9] = mk(1, 1, 8, {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 32'h0},
                 1, {64'h0000_0000_0403_0201, 64'h0}, 0, 1, 1, 1);

    // Reset state, observed asynchronously before any clock edge matters.
    #2 rst = 1'b1;
    #1;
    chk("rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("rst_core_hold", 64'(core_hold), 64'd1);
    chk("rst_store_enable", 64'(store_enable), 64'd0);
    chk("rst_is_sw", 64'(is_sw), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_address", 64'(address), 64'd0);
    chk("rst_data_in", 64'(data_in), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_reset) apply_reset();
      for (int s = 0; s < vecs[i].nstores; s++) exp_q.push_back(vecs[i].stores[s]);
      for (int j = 0; j < vecs[i].nbytes; j++) begin
        send_byte(vecs[i].bytes[j], vecs[i].gaps ? int'($urandom_range(0, 3)) : 0);
      end
      idle(3);
      #1;
      chk($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_error", i), 64'(error), 64'(vecs[i].exp_error));
      chk($sformatf("v%0d_core_hold", i), 64'(core_hold), 64'(vecs[i].exp_hold));
      chk($sformatf("v%0d_rx_ready", i), 64'(rx_ready), 64'(vecs[i].exp_ready));
      chk($sformatf("v%0d_stores_left", i), 64'(exp_q.size()), 64'd0);
      @(negedge clk);
    end

    // Reset after five payload bytes: first word stored, second abandoned.
    apply_reset();
    exp_q.push_back(64'h0000_0000_4433_2211);
    for (int j = 0; j < 8; j++) send_byte(FRAME2[j], 0);
    rx_valid = 1'b0;
    #1;
    chk("mid_pre_data", 64'(data_in), 64'h4433_22DD);
    rst = 1'b1;
    #1;
    chk("mid_rst_data_in", 64'(data_in), 64'd0);
    chk("mid_rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("mid_rst_core_hold", 64'(core_hold), 64'd1);
    chk("mid_rst_store_cnt", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) exp_q.push_back(STORES2[s]);
    for (int j = 0; j < 12; j++) send_byte(FRAME2[j], 0);
    idle(3);
    #1;
    chk("mid_reload_done", 64'(done), 64'd1);
    chk("mid_reload_stores", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    // Reset asserted while the store strobe is up: the store must vanish.
    apply_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    rx_valid = 1'b0;
    #1;
    chk("store_pre_strobe", 64'(store_enable), 64'd1);
    chk("store_pre_data", 64'(data_in), 64'h0403_0201);
    rst = 1'b1;
    #1;
    chk("store_rst_strobe", 64'(store_enable), 64'd0);
    chk("store_rst_is_sw", 64'(is_sw), 64'd0);
    chk("store_rst_address", 64'(address), 64'd0);
    chk("store_rst_data_in", 64'(data_in), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    #1;
    chk("store_after_rst_idle", {61'd0, done, error, store_enable}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop in case a task never returns.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
